// File: rtl/seq_div_8bit.sv
// seq_div_8bit: multi-cycle unsigned restoring divider, one quotient bit per cycle,
// valid/ready handshakes on operands and results.
module seq_div_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] d, v, q, r, r_next, q_next;
  logic [WIDTH:0] s, t;
  logic [CW-1:0] cnt;
  logic last;
  // r always stays below the divisor, so WIDTH bits of partial remainder suffice
  assign s = {r, d[WIDTH-1]};
  assign t = s - {1'b0, v};
  assign r_next = t[WIDTH] ? s[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ~t[WIDTH]};
  assign last = cnt == CW'(WIDTH - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      d <= '0;
      v <= '0;
      r <= '0;
      q <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (divisor == '0) begin
            quotient <= '1;
            remainder <= dividend;
            div_by_zero <= 1'b1;
            state <= DONE;
          end else begin
            d <= dividend;
            v <= divisor;
            r <= '0;
            q <= '0;
            cnt <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          d <= d << 1;
          r <= r_next;
          q <= q_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            quotient <= q_next;
            remainder <= r_next;
            div_by_zero <= 1'b0;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
